// File: rtl/crc32_pkg.sv
// Shared constants and the one-byte reflected CRC-32 step for the crc32_stream block.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'h2144DF1C;

  typedef enum logic {
    ACCUM,
    HOLD
  } crc_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

  // Reflected register: data enters at bit 0 and the register shifts right.
  function automatic logic [31:0] crc32_byte(input logic [7:0] data, input logic [31:0] state);
    logic [31:0] c;
    c = state ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_lane.sv
// One byte position of the per-beat CRC chain; a byte with keep low passes the state through.
module crc32_lane
  import crc32_pkg::*;
(
  input  logic [7:0]  data_i,
  input  logic        keep_i,
  input  logic [31:0] crc_i,
  output logic [31:0] crc_o
);

  assign crc_o = keep_i ? crc32_byte(data_i, crc_i) : crc_i;

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 with byte-enable, frame delimiting and a result handshake.
// Optional frame check output crc_ok is built when CRC32_STREAM_CHECK_EN is defined.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [31:0] INIT       = CRC32_INIT,
  parameter logic [31:0] XOR_OUT    = CRC32_XOR_OUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic                    crc_valid,
  input  logic                    crc_ready,
  output logic [31:0]             crc_out,
  output logic [15:0]             len_out
`ifdef CRC32_STREAM_CHECK_EN
  ,
  output logic                    crc_ok
`endif
);

  crc_state_e  state_q, state_d;
  logic [31:0] run_q, run_d;
  logic [15:0] len_q, len_d;
  logic [31:0] crc_out_q, crc_out_d;
  logic [15:0] len_out_q, len_out_d;

  logic        beat_acc;
  logic        last_acc;
  logic [31:0] beat_crc;
  logic [31:0] crc_fin;
  logic [4:0]  keep_cnt;
  logic [16:0] len_sum;
  logic [15:0] len_next;

  assign crc_valid = (state_q == HOLD);
  assign s_ready   = !crc_valid || crc_ready;
  assign beat_acc  = s_valid && s_ready;
  assign last_acc  = beat_acc && s_last;

  // Byte 0 sits at the head of the chain so it is folded in first.
  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    logic [31:0] crc_in;
    logic [31:0] crc_nx;
    if (g == 0) begin : g_head
      assign crc_in = run_q;
    end else begin : g_tail
      assign crc_in = g_lane[g-1].crc_nx;
    end
    crc32_lane u_lane (
      .data_i (s_data[8*g +: 8]),
      .keep_i (s_keep[g]),
      .crc_i  (crc_in),
      .crc_o  (crc_nx)
    );
  end

  assign beat_crc = g_lane[DATA_BYTES-1].crc_nx;
  assign crc_fin  = beat_crc ^ XOR_OUT;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DATA_BYTES; i++) keep_cnt = keep_cnt + 5'(s_keep[i]);
  end

  assign len_sum  = {1'b0, len_q} + 17'(keep_cnt);
  assign len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    run_d     = run_q;
    len_d     = len_q;
    crc_out_d = crc_out_q;
    len_out_d = len_out_q;

    if (beat_acc) begin
      if (s_last) begin
        run_d     = INIT;
        len_d     = '0;
        crc_out_d = crc_fin;
        len_out_d = len_next;
      end else begin
        run_d = beat_crc;
        len_d = len_next;
      end
    end

    // A last beat landing on the consuming cycle refills HOLD with no bubble.
    case (state_q)
      ACCUM:   if (last_acc) state_d = HOLD;
      HOLD:    if (crc_ready && !last_acc) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      run_q     <= INIT;
      len_q     <= '0;
      crc_out_q <= '0;
      len_out_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      len_q     <= len_d;
      crc_out_q <= crc_out_d;
      len_out_q <= len_out_d;
    end
  end

  assign crc_out = crc_out_q;
  assign len_out = len_out_q;

`ifdef CRC32_STREAM_CHECK_EN
  // A frame ending in its own FCS leaves the fixed residue in the final CRC.
  logic ok_q, ok_d;

  assign ok_d = last_acc ? (crc_fin == CRC32_RESIDUE) : ok_q;

  always_ff @(posedge clk) begin
    if (rst) ok_q <= 1'b0;
    else     ok_q <= ok_d;
  end

  assign crc_ok = ok_q;
`endif

endmodule

// File: doc/crc32_stream.md
# crc32_stream

Streaming CRC-32 (IEEE 802.3, reflected, poly 0x04C11DB7) generator for the packet datapath, generalised to DATA_BYTES bytes per beat with byte-enable, frame delimiting and an output handshake. It sits at the tail of the TX/RX framer. It accumulates one beat per cycle and, for each frame, presents the final CRC and the frame byte count until they are consumed. Back-to-back frames run without idle cycles.

## Interface
- DATA_BYTES, 4: bytes per beat, 1..16.
- INIT, 32'hFFFFFFFF: register value at start of frame.
- XOR_OUT, 32'hFFFFFFFF: final XOR applied to crc_out.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_data  in  8*DATA_BYTES  beat data; byte i = s_data[8i+7:8i]; byte 0 is processed first.
- s_keep  in  DATA_BYTES  byte i included iff s_keep[i].
- s_last  in  1  beat is the final beat of the frame.
- crc_valid  out  1  result pending.
- crc_ready  in  1  result consumed when crc_valid&&crc_ready.
- crc_out  out  32  final CRC: reflected, XOR_OUT applied, Ethernet FCS order (crc_out[7:0] is sent first).
- len_out  out  16  byte count of the frame, saturating at 16'hFFFF.
- crc_ok  out  1  present only with CRC32_STREAM_CHECK_EN.

## Operation
- States: ACCUM (frame open or idle; running register is valid) and HOLD (crc_valid=1).
- s_ready = !crc_valid || crc_ready (combinational). Throughput is one beat per clock.
- Each accepted beat folds bytes 0..DATA_BYTES-1, in ascending order, into the running register. Bytes with keep=0 are skipped; keep need not be contiguous. Each byte is processed LSB-first (reflected).
- len accumulator adds popcount(s_keep) per accepted beat and saturates at 0xFFFF.
- Accepted beat with s_last=1:
  - crc_out <= next^XOR_OUT and len_out <= next len. crc_valid <= 1.
  - Running register <= INIT and len <= 0 in the same cycle, so the next frame may begin on the following beat.
- Zero-byte frame (one beat, keep=0, last=1): crc_out = INIT^XOR_OUT (defaults: 0x00000000), len_out = 0.
- HOLD -> ACCUM on crc_ready with no new last beat.
- Simultaneous crc_ready and accepted last beat: the new result replaces the old one, crc_valid stays 1, and no bubble is inserted.
- Outputs are stable while crc_valid && !crc_ready.
- Input beats with s_valid=0 do not change state, whatever the values of s_data, s_keep and s_last.

## Timing
- Reset values: crc_valid=0, crc_out=0, len_out=0, crc_ok=0. Running register = INIT, len = 0. s_ready=1 in the cycle after reset.
- Latency: crc_valid rises on the clock edge after the last beat is accepted (1 cycle).
- Reset mid-frame discards the partial frame and any pending result. The first beat after reset starts a new frame from INIT.
- The byte chain is purely combinational within one cycle. DATA_BYTES>8 may need a register stage, which is out of scope for this revision.

## Configuration
- CRC32_STREAM_CHECK_EN defined: the crc_ok port and its register exist. The block treats the last 4 bytes of the frame as the received FCS. crc_ok = (crc_out == 32'h2144DF1C), registered together with crc_out. crc_ok is only meaningful with the default INIT and XOR_OUT.
- CRC32_STREAM_CHECK_EN undefined: no crc_ok port and no compare logic. All other behaviour is identical.

## Structure
- Package crc32_pkg holds:
  - CRC32_POLY, CRC32_INIT, CRC32_XOR_OUT, CRC32_RESIDUE (32'h2144DF1C);
  - function crc32_byte(byte, state) giving the one-byte reflected next state.
- Sub-module crc32_lane (combinational): one byte step with keep bypass. It is instantiated DATA_BYTES times in a chain by generate.
- Top level holds the state register, len counter, output registers and handshake.

## Test plan
- Default params: "123456789" as 0x34333231, 0x38373635, then 0x00000039 with keep=0001 and last -> crc_out=0xCBF43926, len_out=9, one cycle after the last beat.
- Zero-byte frame (keep=0000, last) -> crc_out=0x00000000, len_out=0.
- Two back-to-back "123456789" frames with crc_ready=1 -> two results on consecutive result slots, both 0xCBF43926, and s_ready never low.
- crc_ready held low for 5 cycles after a result -> crc_out/len_out stable, s_ready=0, the next beat is accepted only once crc_ready=1.
- rst pulsed after the 0x34333231 beat, then the full "123456789" frame -> 0xCBF43926.
- CHECK_EN: "123456789" followed by FCS bytes 26 39 F4 CB -> crc_ok=1. Flip one data bit -> crc_ok=0.
